square_wave_gen: RTL and testbench

SQUARE_WAVE_GEN -- requirements
Module: square_wave_gen

---
 rtl/square_wave_gen.sv | 112 +++++++++++
 tb/tb_square_wave_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_gen.sv
// Square-wave generator: high for m*DIV cycles, low for n*DIV cycles, repeating
// while en is held. m/n are latched at each period start; en is honoured only at period boundaries.
module square_wave_gen #(
    parameter int W   = 4,
    parameter int DIV = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] m,
    input  logic [W-1:0] n,
    output logic         wave,
    output logic         rise,
    output logic         fall,
    output logic         busy
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [PW-1:0]  pre;
    logic [W-1:0]   unit;
    logic [W-1:0]   m_lat;
    logic [W-1:0]   n_lat;

    logic [W-1:0]   phase_len;
    logic           pre_last;
    logic           phase_done;
    logic           boundary;
    logic           latch;
    logic           wave_d;
    logic           rise_d;
    logic           fall_d;
    logic           busy_d;

    // First state of a new period for a freshly latched m/n pair.
    function automatic state_t start_state(input logic [W-1:0] hm, input logic [W-1:0] hn);
        if (hm != '0)      return HIGH;
        else if (hn != '0) return LOW;
        else               return IDLE;
    endfunction

    // State, counters, latched operands and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the latched m/n are ordinary registers (not a memory), so they are reset like the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pre   <= '0;
            unit  <= '0;
            m_lat <= '0;
            n_lat <= '0;
            wave  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            if (latch) begin
                m_lat <= m;
                n_lat <= n;
            end
            // Counters clear on every phase entry, so they never need to wrap.
            if (state == IDLE || phase_done) begin
                pre  <= '0;
                unit <= '0;
            end else if (pre_last) begin
                pre  <= '0;
                unit <= unit + W'(1);
            end else begin
                pre  <= pre + PW'(1);
            end
            wave <= wave_d;
            rise <= rise_d;
            fall <= fall_d;
            busy <= busy_d;
        end
    end

    // Next-state logic.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch inferred).
    always_comb begin
        phase_len  = (state == HIGH) ? m_lat : n_lat;
        pre_last   = (pre == PW'(DIV - 1));
        phase_done = (state != IDLE) && pre_last && (unit == phase_len - W'(1));
        boundary   = (state == IDLE) ||
                     (phase_done && ((state == LOW) || (n_lat == '0)));
        latch      = boundary && en;
        state_nx   = state;
        if (boundary) begin
            state_nx = en ? start_state(m, n) : IDLE;
        end else if (phase_done) begin
            state_nx = LOW;
        end
    end

    // Output logic: next values of the registered outputs, derived from the next state.
    always_comb begin
        wave_d = (state_nx == HIGH);
        busy_d = (state_nx != IDLE);
        rise_d = wave_d && !wave;
        fall_d = !wave_d && wave;
    end

endmodule

// File: tb/tb_square_wave_gen.sv
// Self-checking bench for square_wave_gen: directed scenarios plus randomized operands,
// compared cycle by cycle against a period-position reference model.
module tb_square_wave_gen;

    localparam int W   = 4;
    localparam int DIV = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] m;
    logic [W-1:0] n;
    logic         wave;
    logic         rise;
    logic         fall;
    logic         busy;

    square_wave_gen #(.W(W), .DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .m     (m),
        .n     (n),
        .wave  (wave),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model: position within the current period and the latched operands.
    bit mod_run;
    int mod_t;
    int mod_m;
    int mod_n;
    bit exp_wave;
    bit exp_rise;
    bit exp_fall;

    // Statistics observed on the DUT within one scenario.
    int rise_cnt;
    int fall_cnt;
    int busy_cnt;
    int hi_len;
    int hi_runs[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        mod_run  = 1'b0;
        mod_t    = 0;
        mod_m    = 0;
        mod_n    = 0;
        exp_wave = 1'b0;
        exp_rise = 1'b0;
        exp_fall = 1'b0;
        hi_len   = 0;
    endtask

    task automatic start_period();
        mod_m   = int'(m);
        mod_n   = int'(n);
        mod_t   = 0;
        mod_run = (mod_m + mod_n) != 0;
    endtask

    task automatic clear_stats();
        rise_cnt = 0;
        fall_cnt = 0;
        busy_cnt = 0;
        hi_runs.delete();
    endtask

    // One clock edge: advance the model, then compare all outputs 1 time unit later.
    task automatic tick();
        bit new_wave;
        @(posedge clk);
        if (!mod_run) begin
            if (en) start_period();
        end else begin
            mod_t++;
            if (mod_t == (mod_m + mod_n) * DIV) begin
                if (en) start_period();
                else    mod_run = 1'b0;
            end
        end
        new_wave = mod_run && (mod_t < mod_m * DIV);
        exp_rise = new_wave && !exp_wave;
        exp_fall = !new_wave && exp_wave;
        exp_wave = new_wave;
        #1;
        check("wave", wave, exp_wave);
        check("rise", rise, exp_rise);
        check("fall", fall, exp_fall);
        check("busy", busy, mod_run);
        if (rise === 1'b1) rise_cnt++;
        if (fall === 1'b1) fall_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (wave === 1'b1) hi_len++;
        else if (hi_len > 0) begin
            hi_runs.push_back(hi_len);
            hi_len = 0;
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        m     = '0;
        n     = '0;
        model_reset();
        clear_stats();
        #1;
        check("rst_wave", wave, 0);
        check("rst_rise", rise, 0);
        check("rst_fall", fall, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(3);

        // m=3, n=2 continuous: 10 rises and 10 falls in 500 cycles.
        clear_stats();
        m = 4'd3; n = 4'd2; en = 1'b1;
        run(500);
        check("cont_rises", rise_cnt, 10);
        check("cont_falls", fall_cnt, 10);
        check("cont_hi0", hi_runs[0], 30);
        en = 1'b0;
        run(10);

        // m changed 3->5 in cycle 12 of HIGH: 30-cycle high now, 50-cycle high next period.
        clear_stats();
        m = 4'd3; n = 4'd2; en = 1'b1;
        run(12);
        m = 4'd5;
        run(108);
        en = 1'b0;
        run(10);
        check("mchg_runs", hi_runs.size(), 2);
        check("mchg_hi0", hi_runs[0], 30);
        check("mchg_hi1", hi_runs[1], 50);

        // en dropped in cycle 5 of HIGH: current period completes, then IDLE.
        clear_stats();
        m = 4'd4; n = 4'd4; en = 1'b1;
        run(5);
        en = 1'b0;
        run(100);
        check("drop_hi0", hi_runs[0], 40);
        check("drop_rises", rise_cnt, 1);
        check("drop_busy_cyc", busy_cnt, 80);
        check("drop_idle", busy, 0);

        // m=0: LOW repeats with no strobes; then m=4, n=0: single rise, fall only on exit.
        clear_stats();
        m = 4'd0; n = 4'd3; en = 1'b1;
        run(100);
        check("m0_rises", rise_cnt, 0);
        check("m0_busy_cyc", busy_cnt, 100);
        clear_stats();
        m = 4'd4; n = 4'd0;
        run(200);
        check("n0_rises", rise_cnt, 1);
        check("n0_falls", fall_cnt, 0);
        en = 1'b0;
        run(50);
        check("n0_exit_falls", fall_cnt, 1);
        check("n0_idle", busy, 0);

        // m=0, n=0: stays idle.
        clear_stats();
        m = 4'd0; n = 4'd0; en = 1'b1;
        run(100);
        check("zero_busy_cyc", busy_cnt, 0);
        check("zero_rises", rise_cnt, 0);
        en = 1'b0;

        // Asynchronous reset mid-HIGH, then restart with m=2.
        clear_stats();
        m = 4'd3; n = 4'd2; en = 1'b1;
        run(10);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wave", wave, 0);
        check("arst_busy", busy, 0);
        check("arst_fall", fall, 0);
        model_reset();
        clear_stats();
        @(negedge clk);
        m = 4'd2;
        rst_n = 1'b1;
        tick();
        check("arst_first_rise", rise, 1);
        run(24);
        check("arst_hi0", hi_runs[0], 20);
        en = 1'b0;
        run(30);

        // Full-range m with a short low phase.
        clear_stats();
        m = 4'd15; n = 4'd1; en = 1'b1;
        run(170);
        check("max_hi0", hi_runs[0], 150);
        en = 1'b0;
        run(170);

        // Randomized operands and run requests.
        for (int s = 0; s < 40; s++) begin
            m  = W'($urandom_range(0, 15));
            n  = W'($urandom_range(0, 15));
            en = ($urandom_range(0, 3) != 0);
            run($urandom_range(20, 80));
        end
        en = 1'b0;
        run(320);
        check("rand_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
